clock_divider_bank: RTL and testbench

- Parametrised successor to the single free-running clock source: a bank of NUM_CH independent, programmable divided clocks and tick strobes, all derived from one system clock.
- Each channel divides by a runtime-programmable ratio. Ratio changes are glitch-free, applied only at period boundaries. A global sync re-aligns all channel phases.
- Feeds timers, UART baud generation and slow peripheral strobes elsewhere in the CPU.

---
 rtl/clock_divider_bank.sv | 115 +++++++++++
 tb/tb_clock_divider_bank.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_divider_bank.sv
// clock_divider_bank: NUM_CH independent programmable clock dividers sharing one
// system clock. Each channel produces a one-cycle tick on the last cycle of its
// period and a divided clock that is high for the first ceil(ratio/2) cycles.
// A new ratio is held in a shadow register and only becomes active at a period
// boundary (wrap), while the channel is idle, or on sync_all, so a period never
// has a partial length.
module clock_divider_bank #(
  parameter int NUM_CH         = 4,
  parameter int WIDTH          = 8,
  parameter int RESET_RATIO_M1 = 1,
  localparam int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NUM_CH-1:0] enable,
  input  logic              sync_all,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [WIDTH-1:0]  cfg_ratio_m1,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] div_clk
);

  localparam logic [CH_W:0]    NUM_CH_V    = (CH_W + 1)'(NUM_CH);
  localparam logic [WIDTH-1:0] RESET_RATIO = WIDTH'(RESET_RATIO_M1);

  // Per-channel registered state.
  logic [NUM_CH-1:0]             en_q, en_d;
  logic [NUM_CH-1:0][WIDTH-1:0]  count_q, count_d;
  logic [NUM_CH-1:0][WIDTH-1:0]  ratio_m1_q, ratio_m1_d;
  logic [NUM_CH-1:0][WIDTH-1:0]  shadow_q, shadow_d;
  logic [NUM_CH-1:0]             pending_q, pending_d;

  // Decode helpers.
  logic [NUM_CH-1:0][WIDTH:0]    half;
  logic                          ch_valid;
  logic                          cfg_accept;

  // Config handshake: a channel accepts a new ratio only when nothing is pending;
  // writes addressed past the last channel are acknowledged and dropped.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    ch_valid   = ({1'b0, cfg_ch} < NUM_CH_V);
    cfg_ready  = 1'b1;
    if (ch_valid) begin
      cfg_ready = !pending_q[cfg_ch];
    end
    cfg_accept = cfg_valid && cfg_ready && ch_valid;
  end

  // Output decode from registered state only; half is one bit wider so that
  // ratio_m1 = 2^WIDTH-1 does not overflow.
  always_comb begin
    half    = '0;
    tick    = '0;
    div_clk = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      half[i]    = ({1'b0, ratio_m1_q[i]} + (WIDTH + 1)'(2)) >> 1;
      tick[i]    = en_q[i] && (count_q[i] == ratio_m1_q[i]);
      div_clk[i] = en_q[i] && ({1'b0, count_q[i]} < half[i]);
    end
  end

  // Next-state: counting, boundary-aligned ratio apply, and shadow capture.
  // tick doubles as the wrap condition since it is en_q && count == ratio_m1.
  always_comb begin
    en_d       = enable;
    count_d    = count_q;
    ratio_m1_d = ratio_m1_q;
    shadow_d   = shadow_q;
    pending_d  = pending_q;
    for (int i = 0; i < NUM_CH; i++) begin
      // Idle, disabling, sync and wrap all restart the period at zero.
      if (sync_all || !enable[i] || !en_q[i] || tick[i]) begin
        count_d[i] = '0;
      end else begin
        count_d[i] = count_q[i] + WIDTH'(1);
      end

      // Pending ratio takes effect only at a boundary so no period is truncated.
      if (pending_q[i] && (sync_all || !en_q[i] || tick[i])) begin
        ratio_m1_d[i] = shadow_q[i];
        pending_d[i]  = 1'b0;
      end

      // Acceptance implies pending_q was clear, so a write landing on a wrap
      // is never applied at that same wrap; it waits for the next boundary.
      if (cfg_accept && (cfg_ch == CH_W'(i))) begin
        shadow_d[i]  = cfg_ratio_m1;
        pending_d[i] = 1'b1;
      end
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clock) begin
    // NOTE: the whole register bank is reset because pending/shadow must never
    // carry a stale write across reset; sequential state uses <= throughout.
    if (reset) begin
      en_q       <= '0;
      count_q    <= '0;
      ratio_m1_q <= {NUM_CH{RESET_RATIO}};
      shadow_q   <= '0;
      pending_q  <= '0;
    end else begin
      en_q       <= en_d;
      count_q    <= count_d;
      ratio_m1_q <= ratio_m1_d;
      shadow_q   <= shadow_d;
      pending_q  <= pending_d;
    end
  end

endmodule

// File: tb/tb_clock_divider_bank.sv
// Directed testbench for clock_divider_bank (NUM_CH=4, WIDTH=8).
// Inputs are driven just after the falling edge; outputs are sampled there too,
// well away from the rising edge. Expected values are hand-computed.
module tb_clock_divider_bank;

  localparam int NUM_CH = 4;
  localparam int WIDTH  = 8;

  logic             clock = 1'b0;
  logic             reset;
  logic [3:0]       enable;
  logic             sync_all;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [1:0]       cfg_ch;
  logic [7:0]       cfg_ratio_m1;
  logic [3:0]       tick;
  logic [3:0]       div_clk;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    logic       chk;
    logic [3:0] en;
    logic       sy;
    logic       cv;
    logic [1:0] ch;
    logic [7:0] r;
    logic [3:0] exp_tick;
    logic [3:0] exp_div;
    logic       exp_ready;
  } vec_t;

  vec_t tbl[$];

  clock_divider_bank #(
    .NUM_CH(NUM_CH),
    .WIDTH(WIDTH),
    .RESET_RATIO_M1(1)
  ) dut (
    .clock(clock),
    .reset(reset),
    .enable(enable),
    .sync_all(sync_all),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch),
    .cfg_ratio_m1(cfg_ratio_m1),
    .tick(tick),
    .div_clk(div_clk)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
    #1;
  endtask

  task automatic add(input logic chk, input logic [3:0] en, input logic sy, input logic cv,
                     input logic [1:0] ch, input logic [7:0] r, input logic [3:0] et,
                     input logic [3:0] ed, input logic er);
    vec_t v;
    v.chk = chk; v.en = en; v.sy = sy; v.cv = cv; v.ch = ch; v.r = r;
    v.exp_tick = et; v.exp_div = ed; v.exp_ready = er;
    tbl.push_back(v);
  endtask

  task automatic run_table(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      enable       = tbl[i].en;
      sync_all     = tbl[i].sy;
      cfg_valid    = tbl[i].cv;
      cfg_ch       = tbl[i].ch;
      cfg_ratio_m1 = tbl[i].r;
      #1;
      if (tbl[i].chk) begin
        check($sformatf("vec%0d tick", i), tick, tbl[i].exp_tick);
        check($sformatf("vec%0d div_clk", i), div_clk, tbl[i].exp_div);
        check($sformatf("vec%0d cfg_ready", i), cfg_ready, tbl[i].exp_ready);
      end
      step();
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = '0; sync_all = 1'b0;
    cfg_valid = 1'b0; cfg_ch = '0; cfg_ratio_m1 = '0;
    step();
    reset = 1'b0;
  endtask

  // Writes one ratio per channel while all channels are idle, so each write
  // is applied on the following edge.
  task automatic program4(input logic [7:0] r0, input logic [7:0] r1,
                          input logic [7:0] r2, input logic [7:0] r3);
    logic [7:0] r [4];
    r[0] = r0; r[1] = r1; r[2] = r2; r[3] = r3;
    for (int k = 0; k < 4; k++) begin
      cfg_valid = 1'b1; cfg_ch = 2'(k); cfg_ratio_m1 = r[k];
      step();
    end
    cfg_valid = 1'b0;
    step();
  endtask

  // Call right after raising enable[ch]: index of the first tick after en_q
  // rises (sample 0 is the cycle with count 0), and div_clk high cycles up to it.
  task automatic first_tick(input int ch, input int budget, output int idx, output int highs);
    idx = -1;
    highs = 0;
    for (int t = 0; t < budget; t++) begin
      step();
      if (idx < 0) begin
        if (div_clk[ch]) highs++;
        if (tick[ch]) idx = t;
      end
    end
  endtask

  initial begin
    int per [4];
    int exp_ticks [4];
    int exp_high [4];
    int ntick [4];
    int nhigh [4];
    int first [4];
    int last [4];
    logic bad [4];
    int idx;
    int highs;
    logic seen;

    // Table A: ratio 2 after reset (indices 0..4).
    add(1, 4'hF, 0, 0, 2'd0, 8'd0, 4'h0, 4'h0, 1);
    add(1, 4'hF, 0, 0, 2'd0, 8'd0, 4'h0, 4'hF, 1);
    add(1, 4'hF, 0, 0, 2'd0, 8'd0, 4'hF, 4'h0, 1);
    add(1, 4'hF, 0, 0, 2'd0, 8'd0, 4'h0, 4'hF, 1);
    add(1, 4'hF, 0, 0, 2'd0, 8'd0, 4'hF, 4'h0, 1);
    // Table C: config handshake, ch1 ratio 4 -> 6, ch2 ratio 2 -> 3 (indices 5..15).
    add(1, 4'h6, 0, 0, 2'd1, 8'd0, 4'h0, 4'h6, 1);
    add(1, 4'h6, 0, 1, 2'd1, 8'd5, 4'h4, 4'h2, 1);
    add(1, 4'h6, 0, 1, 2'd1, 8'd7, 4'h0, 4'h4, 0);
    add(1, 4'h6, 0, 1, 2'd2, 8'd2, 4'h6, 4'h0, 1);
    add(1, 4'h6, 0, 0, 2'd1, 8'd0, 4'h0, 4'h6, 1);
    add(1, 4'h6, 0, 0, 2'd2, 8'd0, 4'h4, 4'h2, 0);
    add(1, 4'h6, 0, 0, 2'd2, 8'd0, 4'h0, 4'h6, 1);
    add(1, 4'h6, 0, 0, 2'd1, 8'd0, 4'h0, 4'h4, 1);
    add(1, 4'h6, 0, 0, 2'd1, 8'd0, 4'h4, 4'h0, 1);
    add(1, 4'h6, 0, 0, 2'd1, 8'd0, 4'h2, 4'h4, 1);
    add(1, 4'h6, 0, 0, 2'd1, 8'd0, 4'h0, 4'h6, 1);
    // Table D: staggered enables, pending ch3 write, then sync_all (indices 16..24).
    add(0, 4'h1, 0, 0, 2'd0, 8'd0, 4'h0, 4'h0, 1);
    add(0, 4'h1, 0, 0, 2'd0, 8'd0, 4'h0, 4'h0, 1);
    add(0, 4'h3, 0, 0, 2'd0, 8'd0, 4'h0, 4'h0, 1);
    add(0, 4'hF, 0, 1, 2'd3, 8'd0, 4'h0, 4'h0, 1);
    add(0, 4'hF, 1, 0, 2'd0, 8'd0, 4'h0, 4'h0, 1);
    add(1, 4'hF, 0, 0, 2'd0, 8'd0, 4'h8, 4'hF, 1);
    add(1, 4'hF, 0, 0, 2'd0, 8'd0, 4'hC, 4'hB, 1);
    add(1, 4'hF, 0, 0, 2'd0, 8'd0, 4'h8, 4'hC, 1);
    add(1, 4'hF, 0, 0, 2'd0, 8'd0, 4'hF, 4'h8, 1);

    // Reset held two cycles with all enables high: outputs stay low.
    reset = 1'b1; enable = 4'hF; sync_all = 1'b0;
    cfg_valid = 1'b0; cfg_ch = '0; cfg_ratio_m1 = '0;
    step();
    check("reset cycle1 tick", tick, 4'h0);
    check("reset cycle1 div_clk", div_clk, 4'h0);
    step();
    check("reset cycle2 tick", tick, 4'h0);
    check("reset cycle2 div_clk", div_clk, 4'h0);
    reset = 1'b0;
    run_table(0, 4);

    // Ratios 1, 3, 4, 256 over one common multiple of all periods (768 cycles).
    do_reset();
    program4(8'd0, 8'd2, 8'd3, 8'd255);
    per       = '{1, 3, 4, 256};
    exp_ticks = '{768, 256, 192, 3};
    exp_high  = '{768, 512, 384, 384};
    for (int c = 0; c < 4; c++) begin
      ntick[c] = 0; nhigh[c] = 0; first[c] = -1; last[c] = -1; bad[c] = 1'b0;
    end
    enable = 4'hF;
    for (int t = 0; t < 768; t++) begin
      step();
      for (int c = 0; c < 4; c++) begin
        if (div_clk[c]) nhigh[c]++;
        if (tick[c]) begin
          if (first[c] < 0) first[c] = t;
          else if (t - last[c] != per[c]) bad[c] = 1'b1;
          last[c] = t;
          ntick[c]++;
        end
      end
    end
    for (int c = 0; c < 4; c++) begin
      check($sformatf("ratio%0d first tick", per[c]), first[c], per[c] - 1);
      check($sformatf("ratio%0d tick spacing", per[c]), bad[c], 1'b0);
      check($sformatf("ratio%0d tick count", per[c]), ntick[c], exp_ticks[c]);
      check($sformatf("ratio%0d high cycles", per[c]), nhigh[c], exp_high[c]);
    end

    // Config handshake on running channels.
    do_reset();
    program4(8'd1, 8'd3, 8'd1, 8'd1);
    enable = 4'h6;
    step();
    run_table(5, 15);

    // sync_all alignment.
    do_reset();
    program4(8'd3, 8'd3, 8'd1, 8'd2);
    run_table(16, 24);

    // Drop enable[0] mid-period (count 1, div_clk high).
    enable = 4'hF; sync_all = 1'b0; cfg_valid = 1'b0;
    step();
    check("ch0 before drop div_clk", div_clk[0], 1'b1);
    enable = 4'hE;
    step();
    check("ch0 after drop div_clk", div_clk[0], 1'b0);
    check("ch0 after drop tick", tick[0], 1'b0);
    seen = 1'b0;
    for (int t = 0; t < 4; t++) begin
      step();
      seen = seen | tick[0] | div_clk[0];
    end
    check("ch0 idle activity", seen, 1'b0);
    enable = 4'hF;
    first_tick(0, 20, idx, highs);
    check("ch0 re-enable first tick", idx, 3);
    check("ch0 re-enable high cycles", highs, 2);

    // Pending ratio on ch1 applied by sync_all coinciding with enable falling.
    cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_ratio_m1 = 8'd4;
    #1;
    check("ch1 write ready", cfg_ready, 1'b1);
    step();
    cfg_valid = 1'b0; enable = 4'hD; sync_all = 1'b1;
    step();
    sync_all = 1'b0;
    #1;
    check("ch1 disabled tick", tick[1], 1'b0);
    check("ch1 disabled div_clk", div_clk[1], 1'b0);
    check("ch1 pending cleared", cfg_ready, 1'b1);
    enable = 4'hF;
    first_tick(1, 20, idx, highs);
    check("ch1 ratio5 first tick", idx, 4);
    check("ch1 ratio5 high cycles", highs, 3);

    // Reset mid-period discards a pending write and restores ratio 2.
    cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_ratio_m1 = 8'd7;
    step();
    cfg_valid = 1'b0; reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    check("post-reset tick", tick, 4'h0);
    check("post-reset div_clk", div_clk, 4'h0);
    check("post-reset ch3 ready", cfg_ready, 1'b1);
    step();
    check("post-reset cycle0 tick", tick, 4'h0);
    check("post-reset cycle0 div_clk", div_clk, 4'hF);
    step();
    check("post-reset cycle1 tick", tick, 4'hF);
    check("post-reset cycle1 div_clk", div_clk, 4'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
